trap_csr_unit: RTL and testbench
================================

# trap_csr_unit

Machine-mode trap and CSR state block, directly downstream of exception detection in the pipelined core. Consumes the exception/mret decision, cause and faulting PC/instruction/address, commits trap state (mepc, mcause, mtval, mstatus, privilege mode) at the clock edge, and drives the fetch redirect. Also hosts the software-visible CSR file and the cycle/instret counters; its privilege-mode output feeds back to exception detection.

## Interface
- RESET_MTVEC, 32'h0000_0000, mtvec value after reset
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- Ei_privRegEnable  in  1  trap or mret in progress this cycle
- Ei_exception  in  1  exception taken this cycle
- Ei_cause  in  4  exception cause code
- Ei_mret  in  1  mret executing this cycle
- Ei_PC  in  32  PC of instruction in stage
- Ei_inst  in  32  instruction word in stage
- Ei_ALUOut  in  32  effective memory address
- Ei_csrOp  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear)
- Ei_csrAddr  in  12  CSR address
- Ei_csrWdata  in  32  CSR write operand (rs1 or zimm)
- Ei_retire  in  1  instruction in stage retires
- Eo_nowPrivMode  out  2  current privilege (2'b11 M, 2'b00 U)
- Eo_csrRdata  out  32  CSR read value
- Eo_redirect  out  1  flush and redirect fetch
- Eo_redirectPC  out  32  redirect target

## Operation
- Implemented CSRs: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82. Unmapped: read 0, write ignored. Access-privilege and read-only checks are done upstream.
- mstatus: only MIE[3], MPIE[7], MPP[12:11] stored; others read 0. MPP write of 01/10 legalises to 00.
- mtvec: direct mode only; bits[1:0] read 0.
- CSR write (Ei_csrOp != 0): new = RW ? wdata : RS ? old|wdata : old&~wdata. RS/RC with wdata=0 writes nothing.
- Trap (Ei_exception=1): mepc <= {Ei_PC[31:2],2'b00}; mcause <= {28'b0,Ei_cause}; mtval <= Ei_PC for cause 0/1, Ei_ALUOut for 5/7, Ei_inst for 2, else 0; MPP <= current priv; MPIE <= MIE; MIE <= 0; priv <= M. CSR write that cycle suppressed.
- mret (Ei_mret=1, Ei_exception=0): priv <= MPP; MIE <= MPIE; MPIE <= 1; MPP <= U.
- Exception outranks mret and CSR write in the same cycle.
- mcycle: 64-bit, +1 every cycle, wraps at 2^64. minstret: +1 when Ei_retire && !Ei_exception. A CSR write to either half overrides that half's increment in that cycle; the other half still carries normally.
- Ei_privRegEnable must equal Ei_exception|Ei_mret; this block gates on Ei_exception/Ei_mret only.

## Timing
- Reset: priv=M, mstatus=0, mtvec=RESET_MTVEC, mscratch/mepc/mcause/mtval=0, counters=0. Outputs after reset: Eo_nowPrivMode=2'b11, Eo_redirect=0, Eo_redirectPC=RESET_MTVEC, Eo_csrRdata=0 for csrAddr unmapped.
- Eo_redirect = Ei_exception|Ei_mret, combinational, same cycle.
- Eo_redirectPC = exception ? {mtvec[31:2],2'b00} : mepc, using pre-edge register values (a same-cycle CSR write is not forwarded).
- Eo_csrRdata combinational from pre-edge value (read-old semantics); counter read shows pre-increment value.
- All state updates at rising clk; Eo_nowPrivMode changes the cycle after trap/mret.
- reset asserted mid-trap: reset wins, no trap state committed.

## Structure
- Package trap_csr_pkg: CSR address constants, privilege-mode constants (M, U), cause codes (0,1,2,5,7,8,11), csrOp encodings, mstatus bit positions.
- Sub-module csr_counter64: 64-bit counter with increment enable and independent lo/hi write ports; instantiated for mcycle and minstret.

## Test plan
- Reset then read 0x300/0x305/0xB00 -> 0, RESET_MTVEC, 0; priv=2'b11.
- U-mode, Ei_exception, cause 5, PC 0x0001_0106, ALUOut 0x1000_0004, mtvec 0x100 -> redirect=1 to 0x100; next cycle mepc=0x0001_0104, mcause=5, mtval=0x1000_0004, MPP=00, priv=11.
- Trap with MIE=1, then mret -> redirect to mepc; after: priv=MPP, MIE=1, MPIE=1, MPP=00.
- Exception and CSR RW to mscratch 0xDEAD same cycle -> mscratch unchanged, trap committed.
- mcycle preset 0xFFFF_FFFF via CSR -> next cycle mcycleh=1, mcycle=0; Ei_retire with Ei_exception -> minstret unchanged.
- RS on mstatus with 0x1808, then RC 0x0008 -> MPP=11, MIE=0; RW MPP=01 -> reads MPP=00.

Source files
------------

// File: rtl/trap_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trap_csr_pkg
// Description : Shared constants for the machine-mode trap/CSR block.
//               CSR addresses, privilege levels, exception cause codes,
//               CSR operation encodings, mstatus bit positions and the
//               read-modify-write helper used by CSR instructions.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package trap_csr_pkg;

  // CSR addresses
  localparam logic [11:0] c_CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] c_CSR_MTVEC     = 12'h305;
  localparam logic [11:0] c_CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] c_CSR_MEPC      = 12'h341;
  localparam logic [11:0] c_CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] c_CSR_MTVAL     = 12'h343;
  localparam logic [11:0] c_CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] c_CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] c_CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] c_CSR_MINSTRETH = 12'hB82;

  // Privilege levels
  localparam logic [1:0] c_PRIV_M = 2'b11;
  localparam logic [1:0] c_PRIV_U = 2'b00;

  // Exception cause codes
  localparam logic [3:0] c_CAUSE_INST_MISALIGN = 4'd0;
  localparam logic [3:0] c_CAUSE_INST_FAULT    = 4'd1;
  localparam logic [3:0] c_CAUSE_ILLEGAL       = 4'd2;
  localparam logic [3:0] c_CAUSE_LOAD_FAULT    = 4'd5;
  localparam logic [3:0] c_CAUSE_STORE_FAULT   = 4'd7;
  localparam logic [3:0] c_CAUSE_ECALL_U       = 4'd8;
  localparam logic [3:0] c_CAUSE_ECALL_M       = 4'd11;

  // CSR operation encodings
  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  // mstatus bit positions
  localparam int c_MSTATUS_MIE    = 3;
  localparam int c_MSTATUS_MPIE   = 7;
  localparam int c_MSTATUS_MPP_LO = 11;
  localparam int c_MSTATUS_MPP_HI = 12;

  // Read-modify-write result of a CSR instruction
  function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                            input logic [31:0] old,
                                            input logic [31:0] wdata);
    logic [31:0] res;
    case (op)
      CSR_RW:  res = wdata;
      CSR_RS:  res = old | wdata;
      CSR_RC:  res = old & ~wdata;
      default: res = old;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter64
// Description : 64-bit free/enable-gated counter with independent 32-bit
//               write ports for each half. A write replaces only its own
//               half; the carry into the upper half is still computed from
//               the pre-write count, so writing the low half does not stop
//               a pending carry into the high half.
// Ports       : clk      - clock
//               rst      - synchronous active-high reset
//               i_inc    - increment enable
//               i_wr_lo  - write low 32 bits with i_wdata
//               i_wr_hi  - write high 32 bits with i_wdata
//               i_wdata  - write data
//               o_count  - current 64-bit count
// Revision    : 1.0 - initial release
// ============================================================================
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_count
);

  logic [63:0] r_count;
  logic [63:0] w_next;

  assign w_next = r_count + {63'd0, i_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 64'd0;
    end else begin
      r_count[31:0]  <= i_wr_lo ? i_wdata : w_next[31:0];
      r_count[63:32] <= i_wr_hi ? i_wdata : w_next[63:32];
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/trap_csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : trap_csr_unit
// Description : Machine-mode trap and CSR state. Commits trap/mret state at
//               the clock edge, drives the fetch redirect, hosts the CSR
//               file and the mcycle/minstret counters.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               Ei_privRegEnable     - trap or mret in progress (informative)
//               Ei_exception/Ei_cause- exception taken and its cause
//               Ei_mret              - mret executing
//               Ei_PC/Ei_inst/Ei_ALUOut - faulting PC, instruction, address
//               Ei_csrOp/Addr/Wdata  - CSR instruction operation
//               Ei_retire            - instruction retires this cycle
//               Eo_nowPrivMode       - current privilege level
//               Eo_csrRdata          - CSR read value (pre-edge)
//               Eo_redirect/PC       - fetch redirect and target
// Revision    : 1.0 - initial release
// ============================================================================
module trap_csr_unit
  import trap_csr_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Ei_privRegEnable,
  input  logic        Ei_exception,
  input  logic [3:0]  Ei_cause,
  input  logic        Ei_mret,
  input  logic [31:0] Ei_PC,
  input  logic [31:0] Ei_inst,
  input  logic [31:0] Ei_ALUOut,
  input  logic [1:0]  Ei_csrOp,
  input  logic [11:0] Ei_csrAddr,
  input  logic [31:0] Ei_csrWdata,
  input  logic        Ei_retire,
  output logic [1:0]  Eo_nowPrivMode,
  output logic [31:0] Eo_csrRdata,
  output logic        Eo_redirect,
  output logic [31:0] Eo_redirectPC
);

  logic [1:0]  r_priv;
  logic        r_mie;
  logic        r_mpie;
  logic [1:0]  r_mpp;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;

  logic [63:0] w_mcycle;
  logic [63:0] w_minstret;
  logic [31:0] w_mstatus;
  logic [31:0] w_rdata;
  logic [31:0] w_new;
  logic [31:0] w_mtval_trap;
  logic [1:0]  w_new_mpp;
  logic        w_mret;
  logic        w_csr_we;
  logic        w_unused;

  // Privilege-enable is redundant with exception|mret; kept only as a port.
  assign w_unused = Ei_privRegEnable;

  assign w_mret = Ei_mret & ~Ei_exception;

  assign w_mstatus = {19'd0, r_mpp, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};

  always_comb begin
    w_rdata = 32'd0;
    case (Ei_csrAddr)
      c_CSR_MSTATUS:   w_rdata = w_mstatus;
      c_CSR_MTVEC:     w_rdata = r_mtvec;
      c_CSR_MSCRATCH:  w_rdata = r_mscratch;
      c_CSR_MEPC:      w_rdata = r_mepc;
      c_CSR_MCAUSE:    w_rdata = r_mcause;
      c_CSR_MTVAL:     w_rdata = r_mtval;
      c_CSR_MCYCLE:    w_rdata = w_mcycle[31:0];
      c_CSR_MINSTRET:  w_rdata = w_minstret[31:0];
      c_CSR_MCYCLEH:   w_rdata = w_mcycle[63:32];
      c_CSR_MINSTRETH: w_rdata = w_minstret[63:32];
      default:         w_rdata = 32'd0;
    endcase
  end

  assign w_new = csr_apply(Ei_csrOp, w_rdata, Ei_csrWdata);

  // Set/clear with a zero operand is a pure read; it must not write, which
  // matters for the counters (a write would cancel that cycle's increment).
  assign w_csr_we = (Ei_csrOp != CSR_NONE) && !Ei_exception &&
                    !((Ei_csrOp == CSR_RS || Ei_csrOp == CSR_RC) &&
                      (Ei_csrWdata == 32'd0));

  // Only M and U exist; reserved MPP encodings collapse to U.
  assign w_new_mpp = (w_new[c_MSTATUS_MPP_HI:c_MSTATUS_MPP_LO] == c_PRIV_M)
                     ? c_PRIV_M : c_PRIV_U;

  always_comb begin
    w_mtval_trap = 32'd0;
    case (Ei_cause)
      c_CAUSE_INST_MISALIGN, c_CAUSE_INST_FAULT: w_mtval_trap = Ei_PC;
      c_CAUSE_LOAD_FAULT, c_CAUSE_STORE_FAULT:   w_mtval_trap = Ei_ALUOut;
      c_CAUSE_ILLEGAL:                           w_mtval_trap = Ei_inst;
      c_CAUSE_ECALL_U, c_CAUSE_ECALL_M:          w_mtval_trap = 32'd0;
      default:                                   w_mtval_trap = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_priv     <= c_PRIV_M;
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mpp      <= c_PRIV_U;
      r_mtvec    <= {RESET_MTVEC[31:2], 2'b00};
      r_mscratch <= 32'd0;
      r_mepc     <= 32'd0;
      r_mcause   <= 32'd0;
      r_mtval    <= 32'd0;
    end else if (Ei_exception) begin
      r_mepc   <= {Ei_PC[31:2], 2'b00};
      r_mcause <= {28'd0, Ei_cause};
      r_mtval  <= w_mtval_trap;
      r_mpp    <= r_priv;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
      r_priv   <= c_PRIV_M;
    end else begin
      if (w_csr_we) begin
        case (Ei_csrAddr)
          c_CSR_MSTATUS: begin
            r_mie  <= w_new[c_MSTATUS_MIE];
            r_mpie <= w_new[c_MSTATUS_MPIE];
            r_mpp  <= w_new_mpp;
          end
          c_CSR_MTVEC:    r_mtvec    <= {w_new[31:2], 2'b00};
          c_CSR_MSCRATCH: r_mscratch <= w_new;
          c_CSR_MEPC:     r_mepc     <= w_new;
          c_CSR_MCAUSE:   r_mcause   <= w_new;
          c_CSR_MTVAL:    r_mtval    <= w_new;
          default: ;
        endcase
      end
      // Placed after the CSR write so mret owns mstatus if both occur.
      if (w_mret) begin
        r_priv <= r_mpp;
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
        r_mpp  <= c_PRIV_U;
      end
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst     (reset),
    .i_inc   (1'b1),
    .i_wr_lo (w_csr_we && (Ei_csrAddr == c_CSR_MCYCLE)),
    .i_wr_hi (w_csr_we && (Ei_csrAddr == c_CSR_MCYCLEH)),
    .i_wdata (w_new),
    .o_count (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst     (reset),
    .i_inc   (Ei_retire & ~Ei_exception),
    .i_wr_lo (w_csr_we && (Ei_csrAddr == c_CSR_MINSTRET)),
    .i_wr_hi (w_csr_we && (Ei_csrAddr == c_CSR_MINSTRETH)),
    .i_wdata (w_new),
    .o_count (w_minstret)
  );

  assign Eo_nowPrivMode = r_priv;
  assign Eo_csrRdata    = w_rdata;
  assign Eo_redirect    = Ei_exception | Ei_mret;
  assign Eo_redirectPC  = w_mret ? r_mepc : r_mtvec;

endmodule
`default_nettype wire

// File: tb/tb_trap_csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_csr_unit
// Description : Self-checking bench for trap_csr_unit. Expected CSR read
//               values are queued when stimulus is applied and popped and
//               compared when the read is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_csr_unit;
  import trap_csr_pkg::*;

  localparam logic [31:0] c_TB_MTVEC = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        reset;
  logic        Ei_privRegEnable;
  logic        Ei_exception;
  logic [3:0]  Ei_cause;
  logic        Ei_mret;
  logic [31:0] Ei_PC;
  logic [31:0] Ei_inst;
  logic [31:0] Ei_ALUOut;
  logic [1:0]  Ei_csrOp;
  logic [11:0] Ei_csrAddr;
  logic [31:0] Ei_csrWdata;
  logic        Ei_retire;
  logic [1:0]  Eo_nowPrivMode;
  logic [31:0] Eo_csrRdata;
  logic        Eo_redirect;
  logic [31:0] Eo_redirectPC;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [11:0] addr;
    logic [31:0] exp;
  } rd_t;
  rd_t sb[$];

  trap_csr_unit #(.RESET_MTVEC(c_TB_MTVEC)) dut (
    .clk              (clk),
    .reset            (reset),
    .Ei_privRegEnable (Ei_privRegEnable),
    .Ei_exception     (Ei_exception),
    .Ei_cause         (Ei_cause),
    .Ei_mret          (Ei_mret),
    .Ei_PC            (Ei_PC),
    .Ei_inst          (Ei_inst),
    .Ei_ALUOut        (Ei_ALUOut),
    .Ei_csrOp         (Ei_csrOp),
    .Ei_csrAddr       (Ei_csrAddr),
    .Ei_csrWdata      (Ei_csrWdata),
    .Ei_retire        (Ei_retire),
    .Eo_nowPrivMode   (Eo_nowPrivMode),
    .Eo_csrRdata      (Eo_csrRdata),
    .Eo_redirect      (Eo_redirect),
    .Eo_redirectPC    (Eo_redirectPC)
  );

  always #10 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic idle();
    Ei_privRegEnable = 1'b0;
    Ei_exception     = 1'b0;
    Ei_cause         = 4'd0;
    Ei_mret          = 1'b0;
    Ei_PC            = 32'd0;
    Ei_inst          = 32'd0;
    Ei_ALUOut        = 32'd0;
    Ei_csrOp         = CSR_NONE;
    Ei_csrAddr       = 12'd0;
    Ei_csrWdata      = 32'd0;
    Ei_retire        = 1'b0;
  endtask

  task automatic push(input string n, input logic [11:0] a, input logic [31:0] v);
    rd_t e;
    e.name = n;
    e.addr = a;
    e.exp  = v;
    sb.push_back(e);
  endtask

  // One CSR instruction cycle, committed at the next edge.
  task automatic csr_op(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    Ei_csrOp = op; Ei_csrAddr = a; Ei_csrWdata = d;
    @(negedge clk);
    idle();
  endtask

  task automatic set_trap(input logic [3:0] cause, input logic [31:0] pc,
                          input logic [31:0] inst, input logic [31:0] alu);
    Ei_privRegEnable = 1'b1; Ei_exception = 1'b1;
    Ei_cause = cause; Ei_PC = pc; Ei_inst = inst; Ei_ALUOut = alu;
  endtask

  task automatic test_reset();
    rd_t e;
    reset = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (Eo_nowPrivMode !== c_PRIV_M) begin errors++; $display("FAIL reset_priv got %h want %h", Eo_nowPrivMode, c_PRIV_M); end
    checks++;
    if (Eo_redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got %b want 0", Eo_redirect); end
    checks++;
    if (Eo_redirectPC !== c_TB_MTVEC) begin errors++; $display("FAIL reset_redirectPC got %h want %h", Eo_redirectPC, c_TB_MTVEC); end
    push("reset_mcycle",   c_CSR_MCYCLE,   32'd0);
    push("reset_mstatus",  c_CSR_MSTATUS,  32'd0);
    push("reset_mtvec",    c_CSR_MTVEC,    c_TB_MTVEC);
    push("reset_minstret", c_CSR_MINSTRET, 32'd0);
    push("reset_unmapped", 12'h7C0,        32'd0);
    push("reset_mscratch", c_CSR_MSCRATCH, 32'd0);
    push("reset_mepc",     c_CSR_MEPC,     32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); Ei_csrAddr = e.addr; #1; checks++;
      if (Eo_csrRdata !== e.exp) begin errors++; $display("FAIL %s rdata=%h want %h", e.name, Eo_csrRdata, e.exp); end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_trap_from_u();
    rd_t e;
    csr_op(CSR_RW, c_CSR_MTVEC, 32'h0000_0103);
    csr_op(CSR_RW, c_CSR_MSTATUS, 32'h0000_0008);
    // mret with MPP=U drops to user mode
    Ei_privRegEnable = 1'b1; Ei_mret = 1'b1;
    #1;
    checks++;
    if (Eo_redirect !== 1'b1) begin errors++; $display("FAIL mret0_redirect got %b want 1", Eo_redirect); end
    checks++;
    if (Eo_redirectPC !== 32'd0) begin errors++; $display("FAIL mret0_redirectPC got %h want 0", Eo_redirectPC); end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (Eo_nowPrivMode !== c_PRIV_U) begin errors++; $display("FAIL mret0_priv got %h want %h", Eo_nowPrivMode, c_PRIV_U); end
    push("mret0_mstatus", c_CSR_MSTATUS, 32'h0000_0080);
    push("mtvec_aligned", c_CSR_MTVEC,   32'h0000_0100);
    while (sb.size() > 0) begin
      e = sb.pop_front(); Ei_csrAddr = e.addr; #1; checks++;
      if (Eo_csrRdata !== e.exp) begin errors++; $display("FAIL %s rdata=%h want %h", e.name, Eo_csrRdata, e.exp); end
    end
    @(negedge clk);
    idle();
    csr_op(CSR_RS, c_CSR_MSTATUS, 32'h0000_0008);
    // load access fault from U-mode
    set_trap(c_CAUSE_LOAD_FAULT, 32'h0001_0106, 32'h1234_5678, 32'h1000_0004);
    #1;
    checks++;
    if (Eo_redirect !== 1'b1) begin errors++; $display("FAIL trap5_redirect got %b want 1", Eo_redirect); end
    checks++;
    if (Eo_redirectPC !== 32'h0000_0100) begin errors++; $display("FAIL trap5_redirectPC got %h want 00000100", Eo_redirectPC); end
    push("trap5_mepc_pre_edge", c_CSR_MEPC, 32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); Ei_csrAddr = e.addr; #1; checks++;
      if (Eo_csrRdata !== e.exp) begin errors++; $display("FAIL %s rdata=%h want %h", e.name, Eo_csrRdata, e.exp); end
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (Eo_nowPrivMode !== c_PRIV_M) begin errors++; $display("FAIL trap5_priv got %h want %h", Eo_nowPrivMode, c_PRIV_M); end
    push("trap5_mepc",    c_CSR_MEPC,    32'h0001_0104);
    push("trap5_mcause",  c_CSR_MCAUSE,  32'd5);
    push("trap5_mtval",   c_CSR_MTVAL,   32'h1000_0004);
    push("trap5_mstatus", c_CSR_MSTATUS, 32'h0000_0080);
    while (sb.size() > 0) begin
      e = sb.pop_front(); Ei_csrAddr = e.addr; #1; checks++;
      if (Eo_csrRdata !== e.exp) begin errors++; $display("FAIL %s rdata=%h want %h", e.name, Eo_csrRdata, e.exp); end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_mret();
    rd_t e;
    Ei_privRegEnable = 1'b1; Ei_mret = 1'b1;
    #1;
    checks++;
    if (Eo_redirectPC !== 32'h0001_0104) begin errors++; $display("FAIL mret1_redirectPC got %h want 00010104", Eo_redirectPC); end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (Eo_nowPrivMode !== c_PRIV_U) begin errors++; $display("FAIL mret1_priv got %h want %h", Eo_nowPrivMode, c_PRIV_U); end
    push("mret1_mstatus", c_CSR_MSTATUS, 32'h0000_0088);
    while (sb.size() > 0) begin
      e = sb.pop_front(); Ei_csrAddr = e.addr; #1; checks++;
      if (Eo_csrRdata !== e.exp) begin errors++; $display("FAIL %s rdata=%h want %h", e.name, Eo_csrRdata, e.exp); end
    end
    @(negedge clk);
    idle();
    // illegal instruction from U, then ecall from M, then mret back to M
    set_trap(c_CAUSE_ILLEGAL, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0005);
    @(negedge clk);
    idle();
    push("ill_mtval",   c_CSR_MTVAL,   32'hDEAD_BEEF);
    push("ill_mcause",  c_CSR_MCAUSE,  32'd2);
    push("ill_mepc",    c_CSR_MEPC,    32'h0000_0040);
    push("ill_mstatus", c_CSR_MSTATUS, 32'h0000_0080);
    while (sb.size() > 0) begin
      e = sb.pop_front(); Ei_csrAddr = e.addr; #1; checks++;
      if (Eo_csrRdata !== e.exp) begin errors++; $display("FAIL %s rdata=%h want %h", e.name, Eo_csrRdata, e.exp); end
    end
    @(negedge clk);
    idle();
    set_trap(c_CAUSE_ECALL_M, 32'h0000_0044, 32'h0000_0073, 32'h0000_0009);
    @(negedge clk);
    idle();
    push("ecall_mtval",   c_CSR_MTVAL,   32'd0);
    push("ecall_mcause",  c_CSR_MCAUSE,  32'd11);
    push("ecall_mstatus", c_CSR_MSTATUS, 32'h0000_1800);
    while (sb.size() > 0) begin
      e = sb.pop_front(); Ei_csrAddr = e.addr; #1; checks++;
      if (Eo_csrRdata !== e.exp) begin errors++; $display("FAIL %s rdata=%h want %h", e.name, Eo_csrRdata, e.exp); end
    end
    @(negedge clk);
    idle();
    Ei_privRegEnable = 1'b1; Ei_mret = 1'b1;
    #1;
    checks++;
    if (Eo_redirectPC !== 32'h0000_0044) begin errors++; $display("FAIL mret2_redirectPC got %h want 00000044", Eo_redirectPC); end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (Eo_nowPrivMode !== c_PRIV_M) begin errors++; $display("FAIL mret2_priv got %h want %h", Eo_nowPrivMode, c_PRIV_M); end
    push("mret2_mstatus", c_CSR_MSTATUS, 32'h0000_0080);
    while (sb.size() > 0) begin
      e = sb.pop_front(); Ei_csrAddr = e.addr; #1; checks++;
      if (Eo_csrRdata !== e.exp) begin errors++; $display("FAIL %s rdata=%h want %h", e.name, Eo_csrRdata, e.exp); end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_exc_priority();
    rd_t e;
    csr_op(CSR_RW, c_CSR_MSCRATCH, 32'h0000_5555);
    // exception, mret and CSR write together: exception alone takes effect
    set_trap(c_CAUSE_INST_FAULT, 32'h2000_0002, 32'h0, 32'h0);
    Ei_mret = 1'b1;
    Ei_csrOp = CSR_RW; Ei_csrAddr = c_CSR_MSCRATCH; Ei_csrWdata = 32'h0000_DEAD;
    #1;
    checks++;
    if (Eo_redirectPC !== 32'h0000_0100) begin errors++; $display("FAIL prio_redirectPC got %h want 00000100", Eo_redirectPC); end
    @(negedge clk);
    idle();
    push("prio_mscratch", c_CSR_MSCRATCH, 32'h0000_5555);
    push("prio_mcause",   c_CSR_MCAUSE,   32'd1);
    push("prio_mepc",     c_CSR_MEPC,     32'h2000_0000);
    push("prio_mtval",    c_CSR_MTVAL,    32'h2000_0002);
    push("prio_mstatus",  c_CSR_MSTATUS,  32'h0000_1800);
    while (sb.size() > 0) begin
      e = sb.pop_front(); Ei_csrAddr = e.addr; #1; checks++;
      if (Eo_csrRdata !== e.exp) begin errors++; $display("FAIL %s rdata=%h want %h", e.name, Eo_csrRdata, e.exp); end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_counters();
    rd_t e;
    csr_op(CSR_RW, c_CSR_MCYCLE, 32'hFFFF_FFFF);
    push("mcycle_preset", c_CSR_MCYCLE, 32'hFFFF_FFFF);
    while (sb.size() > 0) begin
      e = sb.pop_front(); Ei_csrAddr = e.addr; #1; checks++;
      if (Eo_csrRdata !== e.exp) begin errors++; $display("FAIL %s rdata=%h want %h", e.name, Eo_csrRdata, e.exp); end
    end
    @(negedge clk);
    idle();
    push("mcycleh_carry", c_CSR_MCYCLEH,   32'd1);
    push("mcycle_wrap",   c_CSR_MCYCLE,    32'd0);
    push("minstret_zero", c_CSR_MINSTRET,  32'd0);
    push("minstreth_zero",c_CSR_MINSTRETH, 32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); Ei_csrAddr = e.addr; #1; checks++;
      if (Eo_csrRdata !== e.exp) begin errors++; $display("FAIL %s rdata=%h want %h", e.name, Eo_csrRdata, e.exp); end
    end
    @(negedge clk);
    idle();
    // retire together with an exception does not count
    set_trap(c_CAUSE_ECALL_U, 32'h0000_0080, 32'h0000_0073, 32'h0);
    Ei_retire = 1'b1;
    @(negedge clk);
    idle();
    push("minstret_exc", c_CSR_MINSTRET, 32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); Ei_csrAddr = e.addr; #1; checks++;
      if (Eo_csrRdata !== e.exp) begin errors++; $display("FAIL %s rdata=%h want %h", e.name, Eo_csrRdata, e.exp); end
    end
    @(negedge clk);
    idle();
    for (int i = 0; i < 3; i++) begin
      Ei_retire = 1'b1;
      if (i == 2) begin
        push("minstret_pre_inc", c_CSR_MINSTRET, 32'd2);
        while (sb.size() > 0) begin
          e = sb.pop_front(); Ei_csrAddr = e.addr; #1; checks++;
          if (Eo_csrRdata !== e.exp) begin errors++; $display("FAIL %s rdata=%h want %h", e.name, Eo_csrRdata, e.exp); end
        end
      end
      @(negedge clk);
    end
    idle();
    // high-half write while retiring: low half still increments
    Ei_retire = 1'b1;
    csr_op(CSR_RW, c_CSR_MINSTRETH, 32'd7);
    push("minstret_lo_inc", c_CSR_MINSTRET,  32'd4);
    push("minstreth_wr",    c_CSR_MINSTRETH, 32'd7);
    while (sb.size() > 0) begin
      e = sb.pop_front(); Ei_csrAddr = e.addr; #1; checks++;
      if (Eo_csrRdata !== e.exp) begin errors++; $display("FAIL %s rdata=%h want %h", e.name, Eo_csrRdata, e.exp); end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_csr_ops();
    rd_t e;
    logic [1:0]  ops [6];
    logic [31:0] wd  [6];
    logic [31:0] ex  [6];
    ops[0] = CSR_RW; wd[0] = 32'h0000_0000; ex[0] = 32'h0000_0000;
    ops[1] = CSR_RS; wd[1] = 32'h0000_1808; ex[1] = 32'h0000_1808;
    ops[2] = CSR_RC; wd[2] = 32'h0000_0008; ex[2] = 32'h0000_1800;
    ops[3] = CSR_RW; wd[3] = 32'h0000_0800; ex[3] = 32'h0000_0000;
    ops[4] = CSR_RW; wd[4] = 32'h0000_1000; ex[4] = 32'h0000_0000;
    ops[5] = CSR_RW; wd[5] = 32'hFFFF_FFFF; ex[5] = 32'h0000_1888;
    for (int i = 0; i < 6; i++) begin
      csr_op(ops[i], c_CSR_MSTATUS, wd[i]);
      push($sformatf("mstatus_op%0d", i), c_CSR_MSTATUS, ex[i]);
      while (sb.size() > 0) begin
        e = sb.pop_front(); Ei_csrAddr = e.addr; #1; checks++;
        if (Eo_csrRdata !== e.exp) begin errors++; $display("FAIL %s rdata=%h want %h", e.name, Eo_csrRdata, e.exp); end
      end
      @(negedge clk);
      idle();
    end
    // set with zero operand must not write, so mcycle keeps counting
    csr_op(CSR_RW, c_CSR_MCYCLE, 32'h0000_0100);
    Ei_csrOp = CSR_RS; Ei_csrWdata = 32'd0;
    push("mcycle_rs0_before", c_CSR_MCYCLE, 32'h0000_0100);
    while (sb.size() > 0) begin
      e = sb.pop_front(); Ei_csrAddr = e.addr; #1; checks++;
      if (Eo_csrRdata !== e.exp) begin errors++; $display("FAIL %s rdata=%h want %h", e.name, Eo_csrRdata, e.exp); end
    end
    @(negedge clk);
    idle();
    push("mcycle_rs0_after", c_CSR_MCYCLE, 32'h0000_0101);
    while (sb.size() > 0) begin
      e = sb.pop_front(); Ei_csrAddr = e.addr; #1; checks++;
      if (Eo_csrRdata !== e.exp) begin errors++; $display("FAIL %s rdata=%h want %h", e.name, Eo_csrRdata, e.exp); end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid_trap();
    rd_t e;
    csr_op(CSR_RW, c_CSR_MSTATUS, 32'd0);
    Ei_privRegEnable = 1'b1; Ei_mret = 1'b1;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (Eo_nowPrivMode !== c_PRIV_U) begin errors++; $display("FAIL rmt_pre_priv got %h want %h", Eo_nowPrivMode, c_PRIV_U); end
    reset = 1'b1;
    set_trap(c_CAUSE_LOAD_FAULT, 32'h0000_0300, 32'h0, 32'h0000_0077);
    Ei_csrOp = CSR_RW; Ei_csrAddr = c_CSR_MSCRATCH; Ei_csrWdata = 32'h1111_2222;
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    checks++;
    if (Eo_nowPrivMode !== c_PRIV_M) begin errors++; $display("FAIL rmt_priv got %h want %h", Eo_nowPrivMode, c_PRIV_M); end
    push("rmt_mepc",     c_CSR_MEPC,     32'd0);
    push("rmt_mcause",   c_CSR_MCAUSE,   32'd0);
    push("rmt_mtval",    c_CSR_MTVAL,    32'd0);
    push("rmt_mscratch", c_CSR_MSCRATCH, 32'd0);
    push("rmt_mstatus",  c_CSR_MSTATUS,  32'd0);
    push("rmt_mtvec",    c_CSR_MTVEC,    c_TB_MTVEC);
    push("rmt_mcycle",   c_CSR_MCYCLE,   32'd0);
    push("rmt_mcycleh",  c_CSR_MCYCLEH,  32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); Ei_csrAddr = e.addr; #1; checks++;
      if (Eo_csrRdata !== e.exp) begin errors++; $display("FAIL %s rdata=%h want %h", e.name, Eo_csrRdata, e.exp); end
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    test_reset();
    test_trap_from_u();
    test_mret();
    test_exc_priority();
    test_counters();
    test_csr_ops();
    test_reset_mid_trap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
